// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and sizing helper for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    // Iteration counter must be able to hold the full operand width.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// rtl/muldiv_unit_cond_negate.sv - two's-complement negate when neg is set, pass-through otherwise
module cond_negate #(
    parameter int width = 64
) (
    input  logic             neg,
    input  logic [width-1:0] value,
    output logic [width-1:0] result
);

    assign result = neg ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit writing HI/LO; MULDIV_EARLY_OUT_EN enables multiply early exit
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int width = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo
);

    localparam int CW = cnt_width(width);

    md_state_t          state_r;
    md_state_t          state_nx;
    md_op_t             op_r;
    logic [CW-1:0]      cnt_r;
    // Multiply: x_r = shifted multiplicand, y_r = remaining multiplier, p_r = product.
    // Divide:   x_r = divisor, y_r = dividend shifting out / quotient shifting in, p_r = remainder.
    logic [2*width-1:0] x_r;
    logic [width-1:0]   y_r;
    logic [2*width-1:0] p_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic               dz_r;

    logic               signed_in;
    logic               a_neg;
    logic               b_neg;
    logic               div0_in;
    logic [width-1:0]   mag_a;
    logic [width-1:0]   mag_b;
    logic               is_mul;
    logic               last_iter;
    logic [2*width-1:0] sum;
    logic [width:0]     shifted;
    logic [width:0]     diff;
    logic               fits;
    logic [2*width-1:0] prod_fix;
    logic [width-1:0]   quo_fix;
    logic [width-1:0]   rem_fix;

    assign signed_in = ~op[0];
    assign a_neg     = signed_in & a[width-1];
    assign b_neg     = signed_in & b[width-1];
    assign div0_in   = op[1] & (b == '0);
    assign is_mul    = ~op_r[1];

    cond_negate #(.width(width)) u_mag_a (.neg(a_neg), .value(a), .result(mag_a));
    cond_negate #(.width(width)) u_mag_b (.neg(b_neg), .value(b), .result(mag_b));

    cond_negate #(.width(2*width)) u_fix_prod (.neg(neg_lo_r), .value(p_r),            .result(prod_fix));
    cond_negate #(.width(width))   u_fix_quo  (.neg(neg_lo_r), .value(y_r),            .result(quo_fix));
    cond_negate #(.width(width))   u_fix_rem  (.neg(neg_hi_r), .value(p_r[width-1:0]), .result(rem_fix));

    // Shift-add step for multiply, restoring subtract step for divide.
    assign sum     = p_r + x_r;
    assign shifted = {p_r[width-1:0], y_r[width-1]};
    assign fits    = shifted >= {1'b0, x_r[width-1:0]};
    assign diff    = shifted - {1'b0, x_r[width-1:0]};

`ifdef MULDIV_EARLY_OUT_EN
    // A multiply can stop once no set multiplier bits remain after this step.
    assign last_iter = (cnt_r == CW'(width - 1)) || (is_mul && (y_r[width-1:1] == '0));
`else
    assign last_iter = (cnt_r == CW'(width - 1));
`endif

    assign busy        = (state_r != IDLE);
    assign done        = (state_r == DONE);
    assign div_by_zero = done & dz_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: if (start) state_nx = div0_in ? FIX : CALC;
            CALC: if (last_iter) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
        end
    end

    // Operand capture, iteration datapath and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= MD_MULT;
            cnt_r    <= '0;
            x_r      <= '0;
            y_r      <= '0;
            p_r      <= '0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            dz_r     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !flush) begin
                        op_r  <= op;
                        cnt_r <= '0;
                        p_r   <= '0;
                        if (div0_in) begin
                            // Results are fixed constants; park them where FIX reads them.
                            x_r      <= '0;
                            y_r      <= '1;
                            p_r      <= {{width{1'b0}}, a};
                            neg_lo_r <= 1'b0;
                            neg_hi_r <= 1'b0;
                            dz_r     <= 1'b1;
                        end else begin
                            x_r      <= {{width{1'b0}}, op[1] ? mag_b : mag_a};
                            y_r      <= op[1] ? mag_a : mag_b;
                            neg_lo_r <= a_neg ^ b_neg;
                            neg_hi_r <= a_neg;
                            dz_r     <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (is_mul) begin
                        if (y_r[0]) p_r <= sum;
                        x_r <= x_r << 1;
                        y_r <= y_r >> 1;
                    end else if (fits) begin
                        p_r <= {{(width-1){1'b0}}, diff};
                        y_r <= {y_r[width-2:0], 1'b1};
                    end else begin
                        p_r <= {{(width-1){1'b0}}, shifted};
                        y_r <= {y_r[width-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_mul) begin
                            hi <= prod_fix[2*width-1:width];
                            lo <= prod_fix[width-1:0];
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
